// File: rtl/mag_pkg.sv
// mag_pkg: shared widths, window defaults and magnitude sample type
package mag_pkg;
  localparam int DEPTH = 8;
  localparam int LOG2_DEPTH = $clog2(DEPTH);
  localparam int MAG_W = 8;
  localparam int SUM_W = MAG_W + LOG2_DEPTH;
  typedef logic [MAG_W-1:0] mag_t;
endpackage

// File: rtl/window_max_tree.sv
// window_max_tree: combinational balanced compare tree returning the largest of N samples
module window_max_tree
  import mag_pkg::*;
#(
  parameter int N = 8
) (
  input  mag_t din [N],
  output mag_t dmax
);
  mag_t node [2*N-1];
  // heap layout: leaves at N-1.., each inner node keeps the larger child, root at 0
  always_comb begin
    for (int k = 0; k < 2*N-1; k++) node[k] = '0;
    for (int k = 0; k < N; k++) node[N-1+k] = din[k];
    for (int k = N-2; k >= 0; k--) node[k] = node[2*k+1] > node[2*k+2] ? node[2*k+1] : node[2*k+2];
  end
  assign dmax = node[0];
endmodule

// File: rtl/mag_window_stats.sv
// mag_window_stats: sliding-window average, peak, fill count and hysteresis alarm over magnitudes
module mag_window_stats #(
  parameter int DEPTH = mag_pkg::DEPTH,
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  mag_pkg::mag_t         mag_in,
  input  logic                  mag_valid,
  input  logic                  clear,
  input  mag_pkg::mag_t         thr_hi,
  input  mag_pkg::mag_t         thr_lo,
  output mag_pkg::mag_t         avg_out,
  output mag_pkg::mag_t         peak_out,
  output logic [LOG2_DEPTH:0]   fill_count,
  output logic                  alarm,
  output logic                  out_valid
);
  import mag_pkg::*;
  localparam int SW = MAG_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);
  mag_t slots [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [SW-1:0] sum;
  logic req;
  mag_t win_max;
  mag_t new_avg;
  logic alarm_nxt;
  window_max_tree #(.N(DEPTH)) u_max (.din(slots), .dmax(win_max));
  assign new_avg = sum[SW-1:LOG2_DEPTH];
  // set wins over clear so overlapping thresholds resolve to alarm on
  always_comb alarm_nxt = new_avg >= thr_hi ? 1'b1 : new_avg <= thr_lo ? 1'b0 : alarm;
  // stage 1: write the sample, keep a running sum by swapping out the overwritten slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
      wr_ptr     <= '0;
      sum        <= '0;
      fill_count <= '0;
      req        <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
      wr_ptr     <= '0;
      sum        <= '0;
      fill_count <= '0;
      req        <= 1'b0;
    end else begin
      req <= mag_valid;
      if (mag_valid) begin
        slots[wr_ptr] <= mag_in;
        sum           <= sum + SW'(mag_in) - SW'(slots[wr_ptr]);
        wr_ptr        <= wr_ptr + LOG2_DEPTH'(1);
        fill_count    <= fill_count == FULL ? FULL : fill_count + 1'b1;
      end
    end
  end
  // stage 2: publish average, peak and alarm from the updated window with a one-cycle strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_out   <= '0;
      peak_out  <= '0;
      alarm     <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      avg_out   <= '0;
      peak_out  <= '0;
      alarm     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= req;
      if (req) begin
        avg_out  <= new_avg;
        peak_out <= win_max;
        alarm    <= alarm_nxt;
      end
    end
  end
endmodule

// File: tb/tb_mag_window_stats.sv
// tb_mag_window_stats: directed and random stimulus checked against a queue-based window model
module tb_mag_window_stats;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] mag_in = '0;
  logic mag_valid = 1'b0;
  logic clear = 1'b0;
  logic [7:0] thr_hi = 8'd255;
  logic [7:0] thr_lo = 8'd0;
  logic [7:0] avg_out, peak_out;
  logic [3:0] fill_count;
  logic alarm, out_valid;
  int total = 0;
  int bad = 0;
  int q[$];
  bit pend = 0;
  int e_avg = 0, e_peak = 0, e_alarm = 0, e_ov = 0;

  mag_window_stats #(.DEPTH(DEPTH), .LOG2_DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .mag_in(mag_in), .mag_valid(mag_valid), .clear(clear),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .avg_out(avg_out), .peak_out(peak_out),
    .fill_count(fill_count), .alarm(alarm), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend = 0;
    e_avg = 0; e_peak = 0; e_alarm = 0; e_ov = 0;
  endtask

  task automatic model_edge(input bit v, input int d, input bit c);
    int s, m;
    if (pend) begin
      s = 0; m = 0;
      foreach (q[k]) begin
        s += q[k];
        if (q[k] > m) m = q[k];
      end
      e_avg = s / DEPTH;
      e_peak = m;
      e_alarm = (e_avg >= int'(thr_hi)) ? 1 : (e_avg <= int'(thr_lo)) ? 0 : e_alarm;
    end
    e_ov = pend;
    if (c) begin
      model_reset();
    end else begin
      if (v) begin
        q.push_back(d);
        if (q.size() > DEPTH) void'(q.pop_front());
      end
      pend = v;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("avg_out", 32'(avg_out), 32'(e_avg));
    chk("peak_out", 32'(peak_out), 32'(e_peak));
    chk("fill_count", 32'(fill_count), 32'(q.size()));
    chk("alarm", 32'(alarm), 32'(e_alarm));
  endtask

  task automatic cyc(input bit v, input int d, input bit c);
    mag_valid = v;
    mag_in = 8'(d);
    clear = c;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(v, d, c);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // held in reset with a valid sample on the input: nothing moves
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1, 200, 0);
    rst_n = 1'b1;
    cyc(1, 200, 0);
    cyc(0, 0, 0);
    chk("first_avg", 32'(avg_out), 32'd25);
    chk("first_peak", 32'(peak_out), 32'd200);
    chk("first_fill", 32'(fill_count), 32'd1);
    // flush, then fill with 80s and wrap with 16s
    cyc(0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 80, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 16, 0);
    cyc(0, 0, 0);
    chk("wrap_avg", 32'(avg_out), 32'd16);
    chk("wrap_peak", 32'(peak_out), 32'd16);
    // hysteresis walk
    thr_hi = 8'd100;
    thr_lo = 8'd50;
    for (int i = 0; i < DEPTH; i++) cyc(1, 120, 0);
    cyc(0, 0, 0);
    chk("alarm_set", 32'(alarm), 32'd1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 80, 0);
    cyc(0, 0, 0);
    chk("alarm_hold_hi", 32'(alarm), 32'd1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 40, 0);
    cyc(0, 0, 0);
    chk("alarm_cleared", 32'(alarm), 32'd0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 90, 0);
    cyc(0, 0, 0);
    chk("alarm_hold_lo", 32'(alarm), 32'd0);
    // clear beats a same-edge sample and cancels the pending update
    cyc(1, 10, 0);
    cyc(1, 99, 1);
    chk("clear_ov", 32'(out_valid), 32'd0);
    chk("clear_fill", 32'(fill_count), 32'd0);
    cyc(1, 64, 0);
    cyc(0, 0, 0);
    chk("after_clear_avg", 32'(avg_out), 32'd8);
    chk("after_clear_fill", 32'(fill_count), 32'd1);
    // random traffic with drifting thresholds
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        thr_hi = 8'($urandom_range(0, 255));
        thr_lo = 8'($urandom_range(0, 255));
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 63) == 0);
    end
    // asynchronous reset mid-burst, between edges
    for (int i = 0; i < 4; i++) cyc(1, 150 + i, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_avg", 32'(avg_out), 32'd0);
    chk("async_peak", 32'(peak_out), 32'd0);
    chk("async_fill", 32'(fill_count), 32'd0);
    chk("async_alarm", 32'(alarm), 32'd0);
    chk("async_ov", 32'(out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(1, 33, 0);
    cyc(0, 0, 0);
    chk("post_reset_ov", 32'(out_valid), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mag_window_stats.md
Name: mag_window_stats

Overview:
Downstream consumer of the 8-bit magnitude result, i.e. sqrt(x^2 + y^2), produced by the magnitude stage. It keeps a sliding window of the last DEPTH accepted magnitudes and produces four results: a moving average, the window peak, a fill count, and a hysteresis alarm. Output is pipelined, with a one-cycle out_valid strobe per accepted sample.

Parameters:
- DEPTH, 8, window length in samples; power of two, range 2..16.
- LOG2_DEPTH, 3, log2(DEPTH); derived, not overridden independently.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- mag_in, input, 8, unsigned magnitude sample.
- mag_valid, input, 1, mag_in is accepted on the rising edge where this is high; no backpressure.
- clear, input, 1, synchronous window flush.
- thr_hi, input, 8, alarm set threshold.
- thr_lo, input, 8, alarm clear threshold.
- avg_out, output, 8, window average (sum >> LOG2_DEPTH).
- peak_out, output, 8, maximum sample currently in the window.
- fill_count, output, LOG2_DEPTH+1, number of valid samples in the window; saturates at DEPTH.
- alarm, output, 1, hysteresis threshold flag.
- out_valid, output, 1, one-cycle strobe: avg_out, peak_out and alarm have just been updated.

Behaviour:
- Reset (rst_n low, async): buffer slots, wr_ptr, sum, fill_count, avg_out, peak_out, alarm and out_valid all go to 0 immediately.
- Reset mid-stream: the in-flight sample is discarded, no out_valid is issued, and operation restarts cleanly after deassertion.
- Storage: circular buffer of DEPTH x 8-bit, write pointer wr_ptr of LOG2_DEPTH bits, which wraps DEPTH-1 -> 0.
- Stage 1, on the edge where mag_valid=1 and clear=0:
  - buf[wr_ptr] <= mag_in.
  - sum <= sum + mag_in - buf[wr_ptr] (the old slot value, which is 0 while not yet filled).
  - wr_ptr increments.
  - fill_count <= min(fill_count+1, DEPTH).
  - A stage-2 request flag is set.
- Sum width: 8+LOG2_DEPTH bits; it cannot overflow.
- Stage 2, on the edge after stage 1:
  - avg_out <= sum >> LOG2_DEPTH (truncating). Empty slots count as zero, so avg_out ramps up during fill.
  - peak_out <= max over all DEPTH slots.
  - alarm is updated from the new average.
  - out_valid <= 1 for exactly one cycle.
- Latency: sample accepted at edge N -> out_valid high during the cycle after edge N+1.
- Throughput: one sample per clock. Back-to-back mag_valid yields back-to-back out_valid.
- Alarm hysteresis, evaluated on the new average:
  - If new_avg >= thr_hi -> alarm=1.
  - Else if new_avg <= thr_lo -> alarm=0.
  - Otherwise alarm holds.
  - Set has priority when thr_lo >= thr_hi.
  - Alarm is updated only on stage 2.
- Thresholds are sampled at stage-2 time; changing them mid-stream takes effect on the next out_valid.
- clear, synchronous: zeroes buffer, sum, wr_ptr, fill_count, avg_out, peak_out and alarm on the edge.
  - clear beats mag_valid on the same edge; that sample is dropped.
  - clear cancels any pending stage-2 update, so no out_valid follows.
- Outputs hold their values between strobes.
- Full window: fill_count stays at DEPTH and the oldest sample is overwritten, so avg/peak reflect the last DEPTH samples exactly.

Decomposition:
- Shared package mag_pkg holds:
  - DEPTH and LOG2_DEPTH defaults.
  - MAG_W = 8.
  - SUM_W = MAG_W + LOG2_DEPTH.
  - The mag_t typedef (logic [MAG_W-1:0]).
- Sub-module window_max_tree: combinational balanced compare tree over DEPTH mag_t inputs returning the maximum. Instantiated once and registered in stage 2.
- Everything else stays in the top: buffer, sum, pointers, hysteresis.

Test Plan:
1. Hold rst_n=0, drive mag_valid=1, mag_in=200 -> all outputs stay 0 and out_valid never asserts. Release -> the first sample yields avg_out=25, peak_out=200, fill_count=1.
2. Feed 8 consecutive samples of 80, thr_hi=255, thr_lo=0 -> avg_out steps 10,20,...,80; peak_out=80; fill_count saturates at 8; 8 out_valid strobes on consecutive cycles.
3. Wrap-around: after step 2, feed eight samples of 16:
   - avg_out sequence is 72,64,56,48,40,32,24,16.
   - peak_out holds 80 until the 8th 16, then becomes 16.
   - fill_count stays 8.
4. Hysteresis with thr_hi=100, thr_lo=50, window full of 120:
   - alarm=1.
   - Feed 80s until avg_out=80 -> alarm stays 1.
   - Feed 40s until avg_out<=50 -> alarm=0 on that strobe.
   - Rise back to avg 90 -> alarm stays 0.
5. clear=1 and mag_valid=1 (mag_in=99) on the same edge, with an update pending:
   - All outputs read 0 next cycle, with no out_valid.
   - The next sample of 64 gives avg_out=8 and fill_count=1.
6. Assert rst_n low asynchronously between two clock edges mid-burst -> outputs are 0 before the next edge, and no spurious out_valid occurs after release.
